// File: rtl/imem_pkg.sv
// imem_pkg: shared constants and FSM encoding for the instruction-memory boot responder
package imem_pkg;
  localparam int DEF_DEPTH = 256;
  localparam int DEF_AW = 8;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2} state_e;
endpackage

// File: rtl/imem_array.sv
// imem_array: 1W1R synchronous RAM with a registered, enable-gated read port and no reset
module imem_array #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 256,
  parameter int AW = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/imem_boot_responder.sv
// imem_boot_responder: boot-loadable instruction memory answering core fetches with 1-cycle latency
module imem_boot_responder
  import imem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW = DEF_AW
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  boot_add,
  input  logic                  ld_valid,
  input  logic [DATA_WIDTH-1:0] ld_data,
  output logic                  ld_ready,
  output logic                  ld_done,
  input  logic                  fetch_req,
  input  logic [31:0]           A_IMEM,
  output logic [DATA_WIDTH-1:0] Instr_in,
  output logic                  instr_valid,
  output logic                  imem_stall,
  output logic                  addr_err
);
  state_e state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic boot_q, valid_q, valid_d, err_q, err_d, hit_q, hit_d, done_q, done_d;
  logic run, boot_rise, wr, last, bad, serve;
  logic [DATA_WIDTH-1:0] rdata;

  assign run = state_q == RUN;
  assign boot_rise = boot_add & ~boot_q;
  assign wr = state_q == LOAD && boot_add && ld_valid;
  assign last = wptr_q == AW'(DEPTH - 1);
  assign bad = (|A_IMEM[1:0]) || (|A_IMEM[31:AW+2]);
  assign serve = run && fetch_req && !boot_rise;

  always_comb begin
    state_d = state_q == IDLE ? (boot_add ? LOAD : RUN)
            : state_q == LOAD ? ((!boot_add || (wr && last)) ? RUN : LOAD)
            : (boot_rise ? LOAD : RUN);
    wptr_d = (run && boot_rise) ? '0 : (wr && !last) ? wptr_q + AW'(1) : wptr_q;
    valid_d = serve;
    err_d = serve ? bad : err_q;
    // hit selects the RAM word; anything else, including a pending LOAD, shows NOP
    hit_d = serve ? !bad : (state_d == RUN) && hit_q;
    done_d = state_q == LOAD && state_d == RUN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wptr_q <= '0;
      boot_q <= 1'b0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
      hit_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q <= wptr_d;
      boot_q <= boot_add;
      valid_q <= valid_d;
      err_q <= err_d;
      hit_q <= hit_d;
      done_q <= done_d;
    end
  end

  imem_array #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .AW(AW)) u_array (
    .clk(clk),
    .we(wr),
    .waddr(wptr_q),
    .wdata(ld_data),
    .re(serve && !bad),
    .raddr(A_IMEM[AW+1:2]),
    .rdata(rdata)
  );

  assign Instr_in = hit_q ? rdata : DATA_WIDTH'(NOP_WORD);
  assign instr_valid = valid_q;
  assign addr_err = err_q;
  assign ld_done = done_q;
  assign ld_ready = state_q == LOAD;
  assign imem_stall = !run;
endmodule

// File: tb/tb_imem_boot_responder.sv
// tb_imem_boot_responder: directed test with a transaction-level memory model checked every cycle
module tb_imem_boot_responder;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int DEPTH = 256;
  logic clk = 0, rst_n = 1, boot_add = 0, ld_valid = 0, fetch_req = 0;
  logic [31:0] ld_data = 0, A_IMEM = 0;
  logic ld_ready, ld_done, instr_valid, imem_stall, addr_err;
  logic [31:0] Instr_in;
  int total = 0, bad = 0;

  imem_boot_responder dut (
    .clk(clk), .rst_n(rst_n), .boot_add(boot_add), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready), .ld_done(ld_done), .fetch_req(fetch_req), .A_IMEM(A_IMEM),
    .Instr_in(Instr_in), .instr_valid(instr_valid), .imem_stall(imem_stall), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", n, act, exp, $time);
    end
  endtask

  // Model: mode 0=idle 1=loading 2=running, memory as a plain array
  int m_mode = 0, m_wptr = 0;
  bit m_prev = 0;
  logic [31:0] m_mem [DEPTH];
  logic [31:0] e_instr = NOP;
  bit e_valid = 0, e_err = 0, e_done = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_wptr = 0; m_prev = 0;
      e_instr = NOP; e_valid = 0; e_err = 0; e_done = 0;
    end else begin
      bit rise, served, badaddr;
      rise = boot_add && !m_prev;
      served = m_mode == 2 && fetch_req && !rise;
      badaddr = A_IMEM % 4 != 0 || A_IMEM >= 4 * DEPTH;
      e_valid = served;
      e_done = 0;
      if (served) begin
        e_err = badaddr;
        e_instr = badaddr ? NOP : m_mem[A_IMEM / 4];
      end
      if (m_mode == 0) m_mode = boot_add ? 1 : 2;
      else if (m_mode == 1) begin
        if (!boot_add) begin m_mode = 2; e_done = 1; end
        else if (ld_valid) begin
          m_mem[m_wptr] = ld_data;
          if (m_wptr == DEPTH - 1) begin m_mode = 2; e_done = 1; end
          else m_wptr++;
        end
      end else if (rise) begin m_mode = 1; m_wptr = 0; end
      if (!served && m_mode != 2) e_instr = NOP;
      m_prev = boot_add;
    end
  end

  always @(negedge clk) begin
    chk("stall", imem_stall, m_mode != 2);
    chk("ready", ld_ready, m_mode == 1);
    chk("done", ld_done, e_done);
    chk("valid", instr_valid, e_valid);
    chk("err", addr_err, e_err);
    if (!$isunknown(e_instr)) chk("instr", Instr_in, e_instr);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic beat(input logic [31:0] w, input int gap);
    ld_valid = 1; ld_data = w; step();
    ld_valid = 0; repeat (gap) step();
  endtask

  task automatic fetch(input logic [31:0] a);
    fetch_req = 1; A_IMEM = a; step();
  endtask

  task automatic chk_reset(input string n);
    chk({n, "_stall"}, imem_stall, 1'b1);
    chk({n, "_ready"}, ld_ready, 1'b0);
    chk({n, "_done"}, ld_done, 1'b0);
    chk({n, "_valid"}, instr_valid, 1'b0);
    chk({n, "_err"}, addr_err, 1'b0);
    chk({n, "_instr"}, Instr_in, NOP);
  endtask

  initial begin
    logic [31:0] prog [4];
    prog = '{32'h00500093, 32'h00100113, 32'h002081B3, 32'h0000006F};
    #1 rst_n = 0; boot_add = 1;
    repeat (2) step();
    rst_n = 1;
    step();
    for (int i = 0; i < 8; i++) beat(32'hA5A5_0000 + i, 0);
    boot_add = 0; step(); step();
    // 1: reset into RUN, back-to-back fetches of preloaded words
    rst_n = 0; step();
    chk_reset("t1_rst");
    rst_n = 1;
    chk("t1_stall_idle", imem_stall, 1'b1);
    step();
    chk("t1_stall_run", imem_stall, 1'b0);
    for (int i = 0; i < 3; i++) begin
      fetch(32'(i * 4));
      chk("t1_valid", instr_valid, 1'b1);
      chk("t1_word", Instr_in, 32'hA5A5_0000 + 32'(i));
    end
    fetch_req = 0; step();
    chk("t1_idle_valid", instr_valid, 1'b0);
    chk("t1_hold", Instr_in, 32'hA5A5_0002);
    // 2: boot load with gaps
    boot_add = 1; step();
    chk("t2_ready", ld_ready, 1'b1);
    beat(prog[0], 1); beat(prog[1], 2); beat(prog[2], 0); beat(prog[3], 0);
    boot_add = 0; step();
    chk("t2_done", ld_done, 1'b1);
    for (int i = 0; i < 4; i++) begin
      fetch(32'(i * 4));
      chk("t2_word", Instr_in, prog[i]);
    end
    // 3: bad addresses
    fetch(32'h2);
    chk("t3_mis_instr", Instr_in, NOP);
    chk("t3_mis_err", addr_err, 1'b1);
    fetch(32'h400);
    chk("t3_oor_instr", Instr_in, NOP);
    chk("t3_oor_err", addr_err, 1'b1);
    chk("t3_oor_valid", instr_valid, 1'b1);
    fetch(32'h4);
    chk("t3_good_err", addr_err, 1'b0);
    chk("t3_good_word", Instr_in, 32'h00100113);
    fetch_req = 0;
    // 4: fetch while loading is ignored
    boot_add = 1; step();
    fetch(32'h0);
    chk("t4_valid", instr_valid, 1'b0);
    chk("t4_stall", imem_stall, 1'b1);
    chk("t4_instr", Instr_in, NOP);
    fetch_req = 0;
    // 5: full-depth load exits on the last beat with boot_add still high
    for (int i = 0; i < DEPTH; i++) beat(32'h5A00_0000 + 32'(i), 0);
    chk("t5_ready", ld_ready, 1'b0);
    chk("t5_stall", imem_stall, 1'b0);
    fetch(32'h3FC);
    chk("t5_last", Instr_in, 32'h5A00_00FF);
    fetch_req = 0; boot_add = 0; step();
    // 6: reset mid-load, then reload two words
    boot_add = 1; step();
    beat(32'hC000_0000, 0); beat(32'hC000_0001, 0); beat(32'hC000_0002, 0);
    rst_n = 0; #1;
    chk_reset("t6_async");
    step(); step();
    rst_n = 1; step();
    beat(32'hD000_0000, 0); beat(32'hD000_0001, 0);
    boot_add = 0; step();
    fetch(32'h0); chk("t6_w0", Instr_in, 32'hD000_0000);
    fetch(32'h4); chk("t6_w1", Instr_in, 32'hD000_0001);
    fetch(32'h8); chk("t6_w2", Instr_in, 32'hC000_0002);
    fetch_req = 0; step(); step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
